// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage placed after the ALU.
// It accepts one load or store at a time and drives a word-wide req/gnt/rvalid
// data bus. Stores get byte enables and lane-replicated write data. Loads get the
// addressed lane, sign- or zero-extended. Misaligned, illegal and timed-out
// accesses complete with resp_err set.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accessErr;
   logic [3:0]  laneBe;
   logic [31:0] laneData;
   logic [31:0] loadData;
   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic        expired;

   // Decode an incoming request into its error status and bus lane pattern.
   // The width code funct3[1:0] selects byte, half or word.
   always_comb begin
      accessErr = 1'b0;
      laneBe    = 4'b1111;
      laneData  = wdata;
      if (is_store) begin
         if (funct3[2]) accessErr = 1'b1;
      end else if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
         accessErr = 1'b1;
      end
      case (funct3[1:0])
         2'b00: begin
            laneBe   = 4'b0001 << addr[1:0];
            laneData = {4{wdata[7:0]}};
         end
         2'b01: begin
            if (addr[0]) accessErr = 1'b1;
            laneBe   = addr[1] ? 4'b1100 : 4'b0011;
            laneData = {2{wdata[15:0]}};
         end
         default: begin
            if (addr[1:0] != 2'b00) accessErr = 1'b1;
         end
      endcase
      if (!is_store) begin
         laneBe   = 4'b1111;
         laneData = 32'd0;
      end
   end

   // Pick the addressed lane from the returned word and extend it.
   // funct3[2] set means zero-extension (LBU/LHU).
   always_comb begin
      byteSel  = mem_rdata[7:0];
      halfSel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (off_q)
         2'b01:   byteSel = mem_rdata[15:8];
         2'b10:   byteSel = mem_rdata[23:16];
         2'b11:   byteSel = mem_rdata[31:24];
         default: byteSel = mem_rdata[7:0];
      endcase
      case (funct3_q[1:0])
         2'b00:   loadData = {{24{byteSel[7] & ~funct3_q[2]}}, byteSel};
         2'b01:   loadData = {{16{halfSel[15] & ~funct3_q[2]}}, halfSel};
         default: loadData = mem_rdata;
      endcase
   end

   // The timeout counter holds the cycles already spent in ISSUE/WAIT, so the
   // current cycle is number cnt_q+1. Zero disables the timeout.
   assign expired = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) >= TIMEOUT_CYCLES);

   // Next-state logic. A grant or read-valid in the same cycle beats a timeout.
   // Errors are detected on accept and go straight to DONE without touching the bus.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_store_d  = is_store_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               is_store_d  = is_store;
               funct3_d    = funct3;
               off_d       = addr[1:0];
               mem_we_d    = is_store;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_be_d    = laneBe;
               mem_wdata_d = laneData;
               if (accessErr) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  state_d = ISSUE;
                  cnt_d   = 32'd0;
               end
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + 32'd1;
            if (mem_gnt) begin
               if (is_store_q) begin
                  state_d = DONE;
                  err_d   = 1'b0;
                  rdata_d = 32'd0;
               end else begin
                  state_d = WAIT;
               end
            end else if (expired) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 32'd1;
            if (mem_rvalid) begin
               state_d = DONE;
               err_d   = 1'b0;
               rdata_d = loadData;
            end else if (expired) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         is_store_q  <= 1'b0;
         funct3_q    <= 3'd0;
         off_q       <= 2'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_store_q  <= is_store_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE) & ~rst;
   assign resp_valid = (state_q == DONE);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_req    = (state_q == ISSUE);
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit built with a short timeout (4 cycles).
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int nVectors = 0;
   int nMiscompares = 0;

   logic [31:0] rRdata, rAddr, rWdata;
   logic        rErr, rWe, rSeen;
   logic [3:0]  rBe;
   int          rLat, rReqCycles;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison, tallied in nVectors/nMiscompares
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVectors++;
      assert (got === exp) else begin
         nMiscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request to the unit
   task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
      req_valid = 1'b1;
      is_store  = st;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
   endtask

   // Run one access to completion. gntAt is the ISSUE cycle (1-based) that gets
   // the grant, 0 = never. Read data returns the cycle after the grant.
   task automatic runAccess(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int gntAt);
      logic gntGiven;
      gntGiven   = 1'b0;
      rSeen      = 1'b0;
      rLat       = 0;
      rReqCycles = 0;
      rBe        = 4'h0;
      rWe        = 1'b0;
      rAddr      = 32'h0;
      rWdata     = 32'h0;
      applyStimulus(st, f3, a, wd);
      tick();
      req_valid = 1'b0;
      rLat      = 1;
      for (int i = 0; i < 30; i++) begin
         if (resp_valid) begin
            rSeen = 1'b1;
            break;
         end
         if (mem_req) begin
            rReqCycles++;
            if (rReqCycles == 1) begin
               rBe    = mem_be;
               rWe    = mem_we;
               rAddr  = mem_addr;
               rWdata = mem_wdata;
            end
         end
         mem_gnt    = mem_req && (gntAt != 0) && (rReqCycles == gntAt);
         mem_rvalid = gntGiven && !st;
         mem_rdata  = rd;
         tick();
         rLat++;
         if (mem_gnt) gntGiven = 1'b1;
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
      end
      rRdata = resp_rdata;
      rErr   = resp_err;
      checkOutput("respSeen", {31'd0, rSeen}, 32'd1);
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      is_store   = 1'b0;
      funct3     = 3'd0;
      addr       = 32'd0;
      wdata      = 32'd0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      #1;
      checkOutput("rst.req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst.mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rst.mem_be", {28'd0, mem_be}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("idle.req_ready", {31'd0, req_ready}, 32'd1);

      $display("[TB] LB with sign extension");
      runAccess(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 1);
      checkOutput("lb.rdata", rRdata, 32'hFFFF_FF80);
      checkOutput("lb.err", {31'd0, rErr}, 32'd0);
      checkOutput("lb.latency", rLat, 32'd3);
      checkOutput("lb.mem_addr", rAddr, 32'h0000_1000);
      checkOutput("lb.mem_be", {28'd0, rBe}, 32'hF);
      checkOutput("lb.mem_we", {31'd0, rWe}, 32'd0);

      $display("[TB] LHU / LH / LBU / LW");
      runAccess(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h8765_4321, 1);
      checkOutput("lhu.rdata", rRdata, 32'h0000_8765);
      runAccess(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h8765_4321, 1);
      checkOutput("lh.rdata", rRdata, 32'hFFFF_8765);
      runAccess(1'b0, 3'b001, 32'h0000_2000, 32'd0, 32'h8765_C321, 1);
      checkOutput("lh.low.rdata", rRdata, 32'hFFFF_C321);
      runAccess(1'b0, 3'b100, 32'h0000_1002, 32'd0, 32'h80FF_1234, 1);
      checkOutput("lbu.rdata", rRdata, 32'h0000_00FF);
      runAccess(1'b0, 3'b010, 32'h0000_0044, 32'd0, 32'hDEAD_BEEF, 1);
      checkOutput("lw.rdata", rRdata, 32'hDEAD_BEEF);
      checkOutput("lw.mem_addr", rAddr, 32'h0000_0044);

      $display("[TB] stores");
      runAccess(1'b1, 3'b000, 32'h0000_0010, 32'h0000_00AB, 32'd0, 1);
      checkOutput("sb.mem_be", {28'd0, rBe}, 32'h1);
      checkOutput("sb.mem_wdata", rWdata, 32'hABAB_ABAB);
      checkOutput("sb.mem_we", {31'd0, rWe}, 32'd1);
      checkOutput("sb.latency", rLat, 32'd2);
      checkOutput("sb.err", {31'd0, rErr}, 32'd0);
      checkOutput("sb.rdata", rRdata, 32'd0);
      runAccess(1'b1, 3'b000, 32'h0000_0013, 32'h0000_005C, 32'd0, 1);
      checkOutput("sb3.mem_be", {28'd0, rBe}, 32'h8);
      runAccess(1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'd0, 1);
      checkOutput("sh.mem_be", {28'd0, rBe}, 32'hC);
      checkOutput("sh.mem_wdata", rWdata, 32'h1234_1234);
      runAccess(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 1);
      checkOutput("sw.mem_be", {28'd0, rBe}, 32'hF);
      checkOutput("sw.mem_wdata", rWdata, 32'hCAFE_F00D);

      $display("[TB] error accesses");
      runAccess(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'h1111_1111, 1);
      checkOutput("lwmis.err", {31'd0, rErr}, 32'd1);
      checkOutput("lwmis.latency", rLat, 32'd1);
      checkOutput("lwmis.reqCycles", rReqCycles, 32'd0);
      checkOutput("lwmis.rdata", rRdata, 32'd0);
      runAccess(1'b1, 3'b100, 32'h0000_0008, 32'h1, 32'd0, 1);
      checkOutput("sillegal.err", {31'd0, rErr}, 32'd1);
      checkOutput("sillegal.reqCycles", rReqCycles, 32'd0);
      runAccess(1'b0, 3'b011, 32'h0000_0008, 32'd0, 32'd0, 1);
      checkOutput("lillegal.err", {31'd0, rErr}, 32'd1);
      runAccess(1'b1, 3'b001, 32'h0000_0011, 32'h1, 32'd0, 1);
      checkOutput("shmis.err", {31'd0, rErr}, 32'd1);

      $display("[TB] timeout handling");
      runAccess(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h5555_5555, 0);
      checkOutput("tmo.err", {31'd0, rErr}, 32'd1);
      checkOutput("tmo.reqCycles", rReqCycles, 32'd4);
      checkOutput("tmo.latency", rLat, 32'd5);
      checkOutput("tmo.rdata", rRdata, 32'd0);
      runAccess(1'b1, 3'b010, 32'h0000_0048, 32'h0BAD_CAFE, 32'd0, 4);
      checkOutput("gnt4.err", {31'd0, rErr}, 32'd0);
      checkOutput("gnt4.latency", rLat, 32'd5);

      $display("[TB] late rvalid in IDLE");
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7777_7777;
      tick();
      mem_rvalid = 1'b0;
      checkOutput("late.resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("late.req_ready", {31'd0, req_ready}, 32'd1);

      $display("[TB] reset during WAIT");
      applyStimulus(1'b0, 3'b010, 32'h0000_0080, 32'd0);
      tick();
      req_valid = 1'b0;
      checkOutput("rw.issue.mem_req", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rw.mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rw.resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rw.req_ready", {31'd0, req_ready}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h2468_ACE0;
      tick();
      mem_rvalid = 1'b0;
      rst = 1'b0;
      tick();
      checkOutput("rw.after.resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rw.after.req_ready", {31'd0, req_ready}, 32'd1);
      runAccess(1'b0, 3'b010, 32'h0000_0084, 32'd0, 32'h1357_2468, 1);
      checkOutput("rw.next.rdata", rRdata, 32'h1357_2468);
      checkOutput("rw.next.err", {31'd0, rErr}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
